// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, bubble constant and occupancy encoding for the skid pipeline stage
package pipe_pkg;
  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 16;
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;
  function automatic occ_e occ_of(input logic main_v, input logic skid_v);
    return occ_e'({1'b0, main_v} + {1'b0, skid_v});
  endfunction
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+ctrl+data holding register with clear and load
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      data_q  <= '0;
    end else if (ld_i) begin
      valid_q <= valid_i;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end
  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with optional skid entry, halt and flush
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF),
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  logic              main_v, skid_v, acc, drn, take_in, from_skid;
  logic              main_v_d;
  logic [CTRL_W-1:0] main_c, skid_c, main_c_d;
  logic [DATA_W-1:0] main_dat, skid_dat, main_dat_d;
  // in skid mode ready comes only from registered state, cutting the out_ready path
  assign in_ready  = (SKID ? !skid_v : (!main_v || out_ready)) && !hlt && !flush && !rst;
  assign out_valid = main_v && !hlt && !rst;
  assign out_ctrl  = out_valid ? main_c : CTRL_BUBBLE;
  assign out_data  = rst ? '0 : main_dat;
  assign occupancy = rst ? OCC_EMPTY : occ_of(main_v, skid_v);
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;
  assign from_skid = drn && skid_v;
  assign take_in   = acc && (!main_v || drn);
  assign main_v_d   = from_skid || take_in;
  assign main_c_d   = from_skid ? skid_c : take_in ? in_ctrl : CTRL_BUBBLE;
  assign main_dat_d = from_skid ? skid_dat : take_in ? in_data : '0;
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .ld_i    (drn || take_in),
    .valid_i (main_v_d),
    .ctrl_i  (main_c_d),
    .data_i  (main_dat_d),
    .valid_o (main_v),
    .ctrl_o  (main_c),
    .data_o  (main_dat)
  );
  if (SKID) begin : g_skid
    logic skid_ld, skid_v_d;
    assign skid_v_d = acc && main_v && !drn;
    assign skid_ld  = skid_v_d || from_skid;
    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush),
      .ld_i    (skid_ld),
      .valid_i (skid_v_d),
      .ctrl_i  (skid_v_d ? in_ctrl : CTRL_BUBBLE),
      .data_i  (skid_v_d ? in_data : '0),
      .valid_o (skid_v),
      .ctrl_o  (skid_c),
      .data_o  (skid_dat)
    );
  end else begin : g_noskid
    assign skid_v   = 1'b0;
    assign skid_c   = CTRL_BUBBLE;
    assign skid_dat = '0;
  end
endmodule

// File: doc/pipe_stage_skid_reg.md
PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

Interface
REQ-001 Parameter DATA_W, default 96, SHALL set the width of the datapath payload (for example ALU result, store data and instruction).
REQ-002 Parameter CTRL_W, default 16, SHALL set the width of the control payload (re/we, selects, flags, dst reg, branch cond).
REQ-003 Parameter CTRL_BUBBLE, default 0, SHALL be the control value representing a bubble (no side effects downstream).
REQ-004 Parameter SKID, default 1, SHALL select the 2-entry skid mode (1) or the 1-entry pass-through-ready mode (0).
REQ-005 clk  in  1  sole clock, rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 hlt  in  1  global halt; freezes all state.
REQ-008 flush  in  1  squash all held entries.
REQ-009 in_valid  in  1  upstream offers an entry.
REQ-010 in_ready  out  1  stage accepts an entry this cycle.
REQ-011 in_ctrl  in  CTRL_W  upstream control payload.
REQ-012 in_data  in  DATA_W  upstream data payload.
REQ-013 out_valid  out  1  stage offers its head entry.
REQ-014 out_ready  in  1  downstream accepts the head entry.
REQ-015 out_ctrl  out  CTRL_W  head control; equals CTRL_BUBBLE when out_valid=0.
REQ-016 out_data  out  DATA_W  head data payload.
REQ-017 occupancy  out  2  number of valid entries held (0..2).

Function
REQ-018 Accept SHALL occur on a rising edge when in_valid & in_ready; drain SHALL occur when out_valid & out_ready.
REQ-019 SKID=1: in_ready SHALL equal !skid_valid & !hlt & !flush, driven from registered state only, with no combinational path from out_ready.
REQ-020 SKID=0: in_ready SHALL equal (!main_valid | out_ready) & !hlt & !flush.
REQ-021 out_valid SHALL equal main_valid & !hlt.
REQ-022 Latency SHALL be 1 cycle from accept to out_valid when the stage is empty.
REQ-023 An accept with the main entry empty, or draining in the same cycle, SHALL load the main entry; otherwise it SHALL load the skid entry.
REQ-024 On a drain with the skid entry valid, the skid entry SHALL move to main in the same edge. Entries SHALL leave in strict FIFO order.
REQ-025 A simultaneous accept and drain at occupancy 1 SHALL keep occupancy 1. At occupancy 2, accept is impossible (in_ready=0).
REQ-026 With hlt=1, every register SHALL hold its value: no accept, no drain, and occupancy unchanged.
REQ-027 With flush=1, both entries SHALL be cleared to valid=0, ctrl=CTRL_BUBBLE and data=0 at the next edge. in_data is not captured.
REQ-028 Priority SHALL be rst > flush > hlt > normal operation. flush SHALL override hlt.
REQ-029 occupancy SHALL equal main_valid + skid_valid. The value 3 is unreachable.

Reset
REQ-030 While rst=1 at an edge, main and skid SHALL be cleared to valid=0, ctrl=CTRL_BUBBLE and data=0.
REQ-031 While rst=1, outputs SHALL be in_ready=0 (both modes), out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0 and occupancy=0.
REQ-032 Reset mid-transfer SHALL discard any in-flight entries. in_ready SHALL be 1 on the first cycle after rst deasserts, unless hlt or flush is asserted.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the default DATA_W, the default CTRL_W, the CTRL_BUBBLE constant and the occupancy encoding.
REQ-034 One sub-module, pipe_entry, SHALL be instantiated twice (main and skid); SKID=0 SHALL omit the skid instance.
REQ-035 pipe_entry SHALL be a valid+ctrl+data register with load and clear inputs.

Verification
REQ-036 SKID=1: accept A=0x11 and B=0x22 on back-to-back cycles with out_ready=0 -> occupancy=2 and in_ready=0; then raise out_ready -> out_data 0x11 then 0x22 on consecutive cycles.
REQ-037 Continuous in_valid and out_ready=1 for 8 values 1..8 -> out_data 1..8 one per cycle after 1-cycle latency, with occupancy steady at 1.
REQ-038 Occupancy 2, assert hlt for 3 cycles with out_ready=1 -> out_valid=0 and no state change; deassert hlt -> entries drain in order.
REQ-039 Occupancy 2, with flush and hlt both high -> next cycle occupancy=0, out_ctrl=CTRL_BUBBLE and out_data=0; in_data=0x33 offered in the flush cycle never appears.
REQ-040 Occupancy 1, assert rst while in_valid=1 -> out_valid=0 and occupancy=0 after the edge; in_ready=1 on the first cycle after release.
REQ-041 SKID=0: out_ready=1 with in_valid each cycle -> full throughput; out_ready=0 -> in_ready=0 in the same cycle.
